// File: rtl/uart.sv
// ---------------------------------------------------------------------------
// uart -- loopback UART with TX and RX FIFOs.
//
// Frame: start(0), DATA_WIDTH data bits LSB first, even parity, stop(1).
// Each bit lasts SB_TICK oversampling ticks, and one tick occurs every DVSR
// clocks. The serial output feeds the receiver input inside this module, so
// every transmitted word comes back through the RX FIFO.
//
// Ports:
//   UCLK        system clock, rising edge
//   reset       asynchronous, active-low reset
//   W_data      word to transmit, pushed into the TX FIFO when wr_uart=1
//   wr_uart     TX FIFO push request (ignored while tx_full)
//   tx_full     TX FIFO full
//   rd_uart     RX FIFO pop request (ignored while rx_empty)
//   R_data      registered word most recently popped from the RX FIFO
//   rx_empty    RX FIFO empty
//   tx          serial line, idle high
//   parity_err  1 when the last completed frame had a parity mismatch
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

// Small FIFO with registered full/empty flags.
//   clk_i/rst_ni  clock and async active-low reset
//   wr_i/wdata_i  write request and data (dropped while full)
//   rd_i/rdata_o  read request (dropped while empty) and head word
//   full_o/empty_o occupancy flags
module UartFifo #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          wr_i,
  input  logic          rd_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o,
  output logic          full_o,
  output logic          empty_o
);
  localparam int DEPTH = 2 ** AW;
  localparam logic [AW-1:0] ONE = AW'(1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic          full_q, empty_q;
  logic          wrEn, rdEn;

  assign wrEn    = wr_i & ~full_q;
  assign rdEn    = rd_i & ~empty_q;
  assign rdata_o = mem_q[rptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

  // Flags only move when exactly one side is active; a simultaneous
  // read and write leaves the occupancy unchanged.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (wrEn) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= wptr_q + ONE;
      end
      if (rdEn) rptr_q <= rptr_q + ONE;
      if (wrEn && !rdEn) begin
        empty_q <= 1'b0;
        full_q  <= ((wptr_q + ONE) == rptr_q);
      end else if (rdEn && !wrEn) begin
        full_q  <= 1'b0;
        empty_q <= ((rptr_q + ONE) == wptr_q);
      end
    end
  end
endmodule

module uart #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_AW    = 2,
  parameter int DVSR       = 6,
  parameter int SB_TICK    = 16
) (
  input  logic                  UCLK,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] W_data,
  input  logic                  wr_uart,
  output logic                  tx_full,
  input  logic                  rd_uart,
  output logic [DATA_WIDTH-1:0] R_data,
  output logic                  rx_empty,
  output logic                  tx,
  output logic                  parity_err
);
  localparam int CW = (DVSR > 1) ? $clog2(DVSR) : 1;
  localparam int SW = (SB_TICK > 1) ? $clog2(SB_TICK) : 1;
  localparam int NW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [SW-1:0] LAST_TICK = SW'(SB_TICK - 1);
  localparam logic [SW-1:0] MID_TICK  = SW'(SB_TICK / 2 - 1);
  localparam logic [NW-1:0] LAST_BIT  = NW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  logic [CW-1:0]         baudCnt_q;
  logic                  tick;

  state_e                txState_q, txState_d;
  logic [SW-1:0]         txTick_q, txTick_d;
  logic [NW-1:0]         txBit_q, txBit_d;
  logic [DATA_WIDTH-1:0] txShift_q, txShift_d;
  logic                  txPar_q, txPar_d;
  logic                  tx_q, tx_d;
  logic                  txPop, txEmpty;
  logic [DATA_WIDTH-1:0] txHead;

  state_e                rxState_q, rxState_d;
  logic [SW-1:0]         rxTick_q, rxTick_d;
  logic [NW-1:0]         rxBit_q, rxBit_d;
  logic [DATA_WIDTH-1:0] rxShift_q, rxShift_d;
  logic                  rxParBit_q, rxParBit_d;
  logic                  parityErr_q, parityErr_d;
  logic                  rxPush, rxFull, rxLine;
  logic [DATA_WIDTH-1:0] rxHead, rData_q;

  assign tick       = (baudCnt_q == CW'(DVSR - 1));
  assign rxLine     = tx_q;
  assign tx         = tx_q;
  assign R_data     = rData_q;
  assign parity_err = parityErr_q;

  UartFifo #(.DW(DATA_WIDTH), .AW(FIFO_AW)) u_txFifo (
    .clk_i(UCLK), .rst_ni(reset), .wr_i(wr_uart), .rd_i(txPop),
    .wdata_i(W_data), .rdata_o(txHead), .full_o(tx_full), .empty_o(txEmpty)
  );

  // A completed frame is dropped when the RX FIFO has no room.
  UartFifo #(.DW(DATA_WIDTH), .AW(FIFO_AW)) u_rxFifo (
    .clk_i(UCLK), .rst_ni(reset), .wr_i(rxPush & ~rxFull), .rd_i(rd_uart),
    .wdata_i(rxShift_q), .rdata_o(rxHead), .full_o(rxFull), .empty_o(rx_empty)
  );

  always_ff @(posedge UCLK or negedge reset) begin
    if (!reset) begin
      baudCnt_q   <= '0;
      txState_q   <= IDLE;
      txTick_q    <= '0;
      txBit_q     <= '0;
      txShift_q   <= '0;
      txPar_q     <= 1'b0;
      tx_q        <= 1'b1;
      rxState_q   <= IDLE;
      rxTick_q    <= '0;
      rxBit_q     <= '0;
      rxShift_q   <= '0;
      rxParBit_q  <= 1'b0;
      parityErr_q <= 1'b0;
      rData_q     <= '0;
    end else begin
      baudCnt_q   <= tick ? '0 : baudCnt_q + CW'(1);
      txState_q   <= txState_d;
      txTick_q    <= txTick_d;
      txBit_q     <= txBit_d;
      txShift_q   <= txShift_d;
      txPar_q     <= txPar_d;
      tx_q        <= tx_d;
      rxState_q   <= rxState_d;
      rxTick_q    <= rxTick_d;
      rxBit_q     <= rxBit_d;
      rxShift_q   <= rxShift_d;
      rxParBit_q  <= rxParBit_d;
      parityErr_q <= parityErr_d;
      if (rd_uart && !rx_empty) rData_q <= rxHead;
    end
  end

  // Transmitter. A frame only starts on a tick, so the start bit is exactly
  // SB_TICK ticks long; STOP chains straight into the next START when more
  // words are waiting.
  always_comb begin
    txState_d = txState_q;
    txTick_d  = txTick_q;
    txBit_d   = txBit_q;
    txShift_d = txShift_q;
    txPar_d   = txPar_q;
    txPop     = 1'b0;
    case (txState_q)
      IDLE: if (tick && !txEmpty) begin
        txPop     = 1'b1;
        txShift_d = txHead;
        txPar_d   = ^txHead;
        txTick_d  = '0;
        txState_d = START;
      end
      START: if (tick) begin
        if (txTick_q == LAST_TICK) begin
          txTick_d  = '0;
          txBit_d   = '0;
          txState_d = DATA;
        end else txTick_d = txTick_q + SW'(1);
      end
      DATA: if (tick) begin
        if (txTick_q == LAST_TICK) begin
          txTick_d  = '0;
          txShift_d = {1'b0, txShift_q[DATA_WIDTH-1:1]};
          if (txBit_q == LAST_BIT) txState_d = PARITY;
          else txBit_d = txBit_q + NW'(1);
        end else txTick_d = txTick_q + SW'(1);
      end
      PARITY: if (tick) begin
        if (txTick_q == LAST_TICK) begin
          txTick_d  = '0;
          txState_d = STOP;
        end else txTick_d = txTick_q + SW'(1);
      end
      STOP: if (tick) begin
        if (txTick_q == LAST_TICK) begin
          txTick_d = '0;
          if (!txEmpty) begin
            txPop     = 1'b1;
            txShift_d = txHead;
            txPar_d   = ^txHead;
            txState_d = START;
          end else txState_d = IDLE;
        end else txTick_d = txTick_q + SW'(1);
      end
      default: txState_d = IDLE;
    endcase
    // The line is registered from the next state so it changes together
    // with the state register.
    case (txState_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = txShift_d[0];
      PARITY:  tx_d = txPar_d;
      default: tx_d = 1'b1;
    endcase
  end

  // Receiver. Half a bit into the start bit the line is re-checked to reject
  // glitches; from then on every bit is sampled at its middle.
  always_comb begin
    rxState_d   = rxState_q;
    rxTick_d    = rxTick_q;
    rxBit_d     = rxBit_q;
    rxShift_d   = rxShift_q;
    rxParBit_d  = rxParBit_q;
    parityErr_d = parityErr_q;
    rxPush      = 1'b0;
    case (rxState_q)
      IDLE: if (!rxLine) begin
        rxTick_d  = '0;
        rxState_d = START;
      end
      START: if (tick) begin
        if (rxTick_q == MID_TICK) begin
          if (!rxLine) begin
            rxTick_d  = '0;
            rxBit_d   = '0;
            rxState_d = DATA;
          end else rxState_d = IDLE;
        end else rxTick_d = rxTick_q + SW'(1);
      end
      DATA: if (tick) begin
        if (rxTick_q == LAST_TICK) begin
          rxTick_d  = '0;
          rxShift_d = {rxLine, rxShift_q[DATA_WIDTH-1:1]};
          if (rxBit_q == LAST_BIT) rxState_d = PARITY;
          else rxBit_d = rxBit_q + NW'(1);
        end else rxTick_d = rxTick_q + SW'(1);
      end
      PARITY: if (tick) begin
        if (rxTick_q == LAST_TICK) begin
          rxTick_d   = '0;
          rxParBit_d = rxLine;
          rxState_d  = STOP;
        end else rxTick_d = rxTick_q + SW'(1);
      end
      STOP: if (tick) begin
        if (rxTick_q == LAST_TICK) begin
          rxTick_d    = '0;
          rxPush      = 1'b1;
          parityErr_d = (^rxShift_q) ^ rxParBit_q;
          rxState_d   = IDLE;
        end else rxTick_d = rxTick_q + SW'(1);
      end
      default: rxState_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart.sv
`timescale 1ns/1ps

// Self-checking bench for the loopback UART. Words are pushed onto a
// scoreboard queue when written and compared when read back out of RX.
module tb_uart;
  localparam int DW = 8;
  localparam int BIT_CLKS = 96;

  logic          UCLK = 1'b0;
  logic          reset;
  logic [DW-1:0] W_data;
  logic          wr_uart;
  logic          rd_uart;
  logic          tx_full;
  logic [DW-1:0] R_data;
  logic          rx_empty;
  logic          tx;
  logic          parity_err;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] expQ[$];
  logic [DW-1:0] lastRead;
  logic [DW-1:0] fullWords[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
  logic [DW-1:0] frameWord;
  logic          expBit;
  int            occ;
  int            lowLen;
  int            waitCnt;
  bit            acc;

  always #5 UCLK = ~UCLK;

  uart dut (
    .UCLK(UCLK), .reset(reset), .W_data(W_data), .wr_uart(wr_uart),
    .tx_full(tx_full), .rd_uart(rd_uart), .R_data(R_data),
    .rx_empty(rx_empty), .tx(tx), .parity_err(parity_err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one write cycle; accepted words go onto the scoreboard.
  task automatic applyStimulus(input logic [DW-1:0] word, input bit accepted);
    W_data  = word;
    wr_uart = 1'b1;
    if (accepted) expQ.push_back(word);
    @(negedge UCLK);
    wr_uart = 1'b0;
  endtask

  task automatic readAndCheck(input string tag);
    logic [DW-1:0] exp;
    rd_uart = 1'b1;
    @(negedge UCLK);
    rd_uart = 1'b0;
    exp = expQ.pop_front();
    checkOutput(tag, R_data, exp);
    checkOutput({tag, "_parity"}, parity_err, 0);
    lastRead = exp;
  endtask

  task automatic waitRx(input string tag);
    int n = 0;
    while (rx_empty && n < 3000) begin
      @(negedge UCLK);
      n++;
    end
    checkOutput({tag, "_arrived"}, rx_empty, 0);
  endtask

  task automatic waitTxLow(input string tag);
    int n = 0;
    while (tx && n < 200) begin
      @(negedge UCLK);
      n++;
    end
    checkOutput({tag, "_start_seen"}, tx, 0);
  endtask

  initial begin
    reset = 1'b0; wr_uart = 1'b0; rd_uart = 1'b0; W_data = '0; lastRead = '0;
    repeat (10) @(negedge UCLK);
    checkOutput("reset_tx", tx, 1);
    checkOutput("reset_rx_empty", rx_empty, 1);
    checkOutput("reset_tx_full", tx_full, 0);
    checkOutput("reset_rdata", R_data, 0);
    checkOutput("reset_parity", parity_err, 0);

    // Baud counter restarts at 0, so the first tick (and first TX pop)
    // comes DVSR cycles after release: five back-to-back writes see no pop.
    reset = 1'b1;
    occ = 0;
    for (int i = 0; i < 5; i++) begin
      acc = (occ < 4);
      applyStimulus(fullWords[i], acc);
      if (acc) occ++;
      checkOutput($sformatf("full_flag_w%0d", i), tx_full, (occ == 4));
    end
    for (int i = 0; i < 4; i++) begin
      waitRx($sformatf("full_word%0d", i));
      readAndCheck($sformatf("full_word%0d", i));
    end
    repeat (1300) @(negedge UCLK);
    checkOutput("full_no_fifth", rx_empty, 1);
    checkOutput("full_flag_cleared", tx_full, 0);

    // Loopback with fixed waits.
    applyStimulus(8'hAA, 1'b1);
    applyStimulus(8'h55, 1'b1);
    repeat (1120) @(negedge UCLK);
    readAndCheck("loop_first");
    repeat (1120) @(negedge UCLK);
    readAndCheck("loop_second");
    checkOutput("loop_rx_empty", rx_empty, 1);

    // Read while empty leaves R_data alone.
    rd_uart = 1'b1;
    @(negedge UCLK);
    rd_uart = 1'b0;
    checkOutput("empty_rdata", R_data, lastRead);
    checkOutput("empty_flag", rx_empty, 1);

    // Frame shape on the line.
    frameWord = 8'h01;
    applyStimulus(frameWord, 1'b1);
    waitTxLow("frame");
    lowLen = 0;
    while (tx == 1'b0 && lowLen < 200) begin
      lowLen++;
      @(negedge UCLK);
    end
    checkOutput("frame_start_len", lowLen, BIT_CLKS);
    repeat (BIT_CLKS / 2) @(negedge UCLK);
    for (int j = 0; j < DW + 2; j++) begin
      if (j < DW) expBit = frameWord[j];
      else if (j == DW) expBit = ^frameWord;
      else expBit = 1'b1;
      checkOutput($sformatf("frame_bit%0d", j), tx, expBit);
      if (j < DW + 1) repeat (BIT_CLKS) @(negedge UCLK);
    end
    waitRx("frame_rx");
    readAndCheck("frame_rx");

    // Reset halfway through a frame of zeros.
    applyStimulus(8'h00, 1'b1);
    waitTxLow("midframe");
    repeat (528) @(negedge UCLK);
    checkOutput("midframe_tx_low", tx, 0);
    #1 reset = 1'b0;
    #1 checkOutput("midframe_tx_reset", tx, 1);
    expQ.delete();
    repeat (3) @(negedge UCLK);
    reset = 1'b1;
    waitCnt = 0;
    repeat (1200) @(negedge UCLK);
    checkOutput("midframe_rx_empty", rx_empty, 1);
    checkOutput("midframe_rdata", R_data, 0);
    checkOutput("midframe_tx_idle", tx, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
